// File: rtl/spi_rxc.sv
// spi_rxc: SPI receive controller, 8/16/32-bit words with frame counting.
// Optional trailing CRC check is compiled in with `define SPI_RXC_CRC_EN.
module spi_rxc #(
    parameter int W_CNT = 13
) (
    input  logic             sclk_rx,
    input  logic             spi_rx_rstn,
    input  logic             rx_en,
    input  logic             shift_in,
    input  logic [1:0]       df,
    input  logic             lsbf,
    input  logic [W_CNT-1:0] spi_rnum_max,
    input  logic             crc_en,
    input  logic [31:0]      crc_poly,
    input  logic             rx_rd,
    output logic [31:0]      spi_rx_data,
    output logic             rx_data_valid,
    output logic             rx_full,
    output logic             rx_ovr,
    output logic             rx_num_max_en,
    output logic             rx_crc_en,
    output logic [31:0]      rx_crc_data_out,
    output logic             crc_err,
    output logic             rx_done
);

    localparam int WC1 = W_CNT + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CRC,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [1:0]       df_q;
    logic             lsbf_q;
    logic [W_CNT-1:0] max_q;
    logic [4:0]       bit_cnt;
    logic [W_CNT-1:0] frame_cnt;
    logic [31:0]      shreg;

    logic             start;
    logic             sampling;
    logic             in_data;
    logic [1:0]       df_e;
    logic             lsbf_e;
    logic [W_CNT-1:0] max_e;
    logic [W_CNT-1:0] max_n;
    logic [4:0]       last_idx;
    logic [31:0]      mask;
    logic [4:0]       bit_e;
    logic [31:0]      sh_e;
    logic [W_CNT-1:0] fc_e;
    logic [31:0]      sh_next;
    logic [31:0]      word;
    logic             frame_end;
    logic             data_end;
    logic             crc_end;
    logic             is_last;
    logic             next_last;
    logic             crc_on;

    logic [31:0]      data_d;
    logic             valid_d;
    logic             full_d;
    logic             ovr_d;
    logic             nmax_d;
    logic             done_d;

    // The IDLE edge that sees rx_en high is also the first data edge,
    // so effective config and counters come from the raw inputs there.
    always_comb begin
        start    = (state == S_IDLE) && rx_en;
        in_data  = start || (state == S_DATA);
        sampling = rx_en && (in_data || (state == S_CRC));
        df_e     = start ? df : df_q;
        lsbf_e   = start ? lsbf : lsbf_q;
        max_e    = start ? spi_rnum_max : max_q;
        max_n    = (max_e == '0) ? W_CNT'(1) : max_e;
        unique case (1'b1)
            df_e == 2'b01: last_idx = 5'd15;
            df_e == 2'b10: last_idx = 5'd31;
            default:       last_idx = 5'd7;
        endcase
        mask  = 32'hFFFF_FFFF >> (5'd31 - last_idx);
        bit_e = start ? 5'd0 : bit_cnt;
        sh_e  = start ? 32'd0 : shreg;
        fc_e  = start ? '0 : frame_cnt;
        if (lsbf_e) begin
            sh_next = (sh_e >> 1) | ({31'd0, shift_in} << last_idx);
        end else begin
            sh_next = {sh_e[30:0], shift_in};
        end
        word      = sh_next & mask;
        frame_end = sampling && (bit_e == last_idx);
        data_end  = frame_end && in_data;
        crc_end   = frame_end && (state == S_CRC);
        is_last   = ({1'b0, fc_e} + WC1'(1)) == {1'b0, max_n};
        next_last = ({1'b0, fc_e} + WC1'(2)) == {1'b0, max_n};
    end

    always_ff @(posedge sclk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (!rx_en) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_d = S_DATA;
                S_DATA: begin
                    if (data_end && is_last) begin
                        state_d = crc_on ? S_CRC : S_DONE;
                    end
                end
                S_CRC: begin
                    if (crc_end) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_DONE;
            endcase
        end
    end

    always_comb begin
        data_d  = data_end ? word : spi_rx_data;
        valid_d = data_end;
        full_d  = data_end ? 1'b1 : (rx_full && !rx_rd);
        ovr_d   = rx_ovr || (data_end && rx_full && !rx_rd);
        done_d  = (data_end && is_last && !crc_on) || crc_end;
        nmax_d  = rx_num_max_en;
        if (!rx_en) begin
            nmax_d = 1'b0;
        end else if (data_end) begin
            nmax_d = !is_last && next_last;
        end else if (start) begin
            nmax_d = is_last;
        end
    end

    always_ff @(posedge sclk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            df_q          <= 2'b00;
            lsbf_q        <= 1'b0;
            max_q         <= '0;
            bit_cnt       <= 5'd0;
            frame_cnt     <= '0;
            shreg         <= 32'd0;
            spi_rx_data   <= 32'd0;
            rx_data_valid <= 1'b0;
            rx_full       <= 1'b0;
            rx_ovr        <= 1'b0;
            rx_num_max_en <= 1'b0;
            rx_done       <= 1'b0;
        end else begin
            if (start) begin
                df_q   <= df;
                lsbf_q <= lsbf;
                max_q  <= spi_rnum_max;
            end
            if (!rx_en) begin
                bit_cnt <= 5'd0;
                shreg   <= 32'd0;
            end else if (sampling) begin
                bit_cnt <= frame_end ? 5'd0 : bit_e + 5'd1;
                shreg   <= frame_end ? 32'd0 : sh_next;
            end
            if (rx_en && in_data) begin
                frame_cnt <= data_end ? fc_e + W_CNT'(1) : fc_e;
            end
            spi_rx_data   <= data_d;
            rx_data_valid <= valid_d;
            rx_full       <= full_d;
            rx_ovr        <= ovr_d;
            rx_num_max_en <= nmax_d;
            rx_done       <= done_d;
        end
    end

`ifdef SPI_RXC_CRC_EN
    logic        crc_en_q;
    logic [31:0] crc_q;
    logic [31:0] crc_b;
    logic [31:0] crc_upd;
    logic        fb;
    logic        crc_err_q;
    logic        crc_act_q;

    assign crc_on = start ? crc_en : crc_en_q;

    // Only data bits feed the CRC; the CRC frame itself is compared, not folded in.
    always_comb begin
        crc_b   = start ? 32'd0 : crc_q;
        fb      = crc_b[last_idx] ^ shift_in;
        crc_upd = ((crc_b << 1) & mask) ^ (fb ? (crc_poly & mask) : 32'd0);
    end

    always_ff @(posedge sclk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            crc_en_q  <= 1'b0;
            crc_q     <= 32'd0;
            crc_err_q <= 1'b0;
            crc_act_q <= 1'b0;
        end else begin
            if (start) begin
                crc_en_q <= crc_en;
            end
            if (rx_en && in_data) begin
                crc_q <= crc_upd;
            end
            if (start) begin
                crc_err_q <= 1'b0;
            end else if (crc_end) begin
                crc_err_q <= (word != crc_q);
            end
            if (!rx_en || crc_end) begin
                crc_act_q <= 1'b0;
            end else if (data_end && is_last && crc_on) begin
                crc_act_q <= 1'b1;
            end
        end
    end

    assign rx_crc_en       = crc_act_q;
    assign rx_crc_data_out = crc_q;
    assign crc_err         = crc_err_q;
`else
    logic unused_crc;

    assign unused_crc      = ^{crc_en, crc_poly};
    assign crc_on          = 1'b0;
    assign rx_crc_en       = 1'b0;
    assign rx_crc_data_out = 32'd0;
    assign crc_err         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rxc.sv
// tb_spi_rxc: directed self-checking bench for spi_rxc.
// CRC scenarios run only when SPI_RXC_CRC_EN is defined.
module tb_spi_rxc;

    logic        sclk_rx;
    logic        spi_rx_rstn;
    logic        rx_en;
    logic        shift_in;
    logic [1:0]  df;
    logic        lsbf;
    logic [12:0] spi_rnum_max;
    logic        crc_en;
    logic [31:0] crc_poly;
    logic        rx_rd;
    logic [31:0] spi_rx_data;
    logic        rx_data_valid;
    logic        rx_full;
    logic        rx_ovr;
    logic        rx_num_max_en;
    logic        rx_crc_en;
    logic [31:0] rx_crc_data_out;
    logic        crc_err;
    logic        rx_done;

    int errors = 0;
    int checks = 0;

    spi_rxc #(.W_CNT(13)) dut (
        .sclk_rx        (sclk_rx),
        .spi_rx_rstn    (spi_rx_rstn),
        .rx_en          (rx_en),
        .shift_in       (shift_in),
        .df             (df),
        .lsbf           (lsbf),
        .spi_rnum_max   (spi_rnum_max),
        .crc_en         (crc_en),
        .crc_poly       (crc_poly),
        .rx_rd          (rx_rd),
        .spi_rx_data    (spi_rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_full        (rx_full),
        .rx_ovr         (rx_ovr),
        .rx_num_max_en  (rx_num_max_en),
        .rx_crc_en      (rx_crc_en),
        .rx_crc_data_out(rx_crc_data_out),
        .crc_err        (crc_err),
        .rx_done        (rx_done)
    );

    initial sclk_rx = 1'b0;
    always #5 sclk_rx = ~sclk_rx;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk_rx);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input int w, input int lo,
                        input int hi, input bit lsb, input bit rd_last);
        for (int i = lo; i < hi; i++) begin
            shift_in = lsb ? v[i] : v[w-1-i];
            rx_rd    = rd_last && (i == hi - 1);
            tick();
        end
        rx_rd = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, spi_rx_data, 32'd0);
        check({tag, "_valid"}, {31'd0, rx_data_valid}, 32'd0);
        check({tag, "_full"}, {31'd0, rx_full}, 32'd0);
        check({tag, "_ovr"}, {31'd0, rx_ovr}, 32'd0);
        check({tag, "_nmax"}, {31'd0, rx_num_max_en}, 32'd0);
        check({tag, "_crcen"}, {31'd0, rx_crc_en}, 32'd0);
        check({tag, "_crcout"}, rx_crc_data_out, 32'd0);
        check({tag, "_crcerr"}, {31'd0, crc_err}, 32'd0);
        check({tag, "_done"}, {31'd0, rx_done}, 32'd0);
    endtask

    task automatic idle_gap();
        rx_en = 1'b0;
        tick();
    endtask

    initial begin
        spi_rx_rstn  = 1'b0;
        rx_en        = 1'b0;
        shift_in     = 1'b0;
        df           = 2'b00;
        lsbf         = 1'b0;
        spi_rnum_max = 13'd1;
        crc_en       = 1'b0;
        crc_poly     = 32'd0;
        rx_rd        = 1'b0;
        #12;
        check_zero("rst");
        tick();
        spi_rx_rstn = 1'b1;

        // 8-bit MSB-first 0x5A, df changed mid-frame must be ignored
        rx_en = 1'b1;
        send(32'h5A, 8, 0, 1, 1'b0, 1'b0);
        check("t1_nmax", {31'd0, rx_num_max_en}, 32'd1);
        send(32'h5A, 8, 1, 4, 1'b0, 1'b0);
        df = 2'b10;
        send(32'h5A, 8, 4, 7, 1'b0, 1'b0);
        check("t1_valid_early", {31'd0, rx_data_valid}, 32'd0);
        send(32'h5A, 8, 7, 8, 1'b0, 1'b0);
        df = 2'b00;
        check("t1_data", spi_rx_data, 32'h0000_005A);
        check("t1_valid", {31'd0, rx_data_valid}, 32'd1);
        check("t1_done", {31'd0, rx_done}, 32'd1);
        check("t1_full", {31'd0, rx_full}, 32'd1);
        check("t1_nmax_off", {31'd0, rx_num_max_en}, 32'd0);
        shift_in = 1'b1;
        tick();
        check("t1_valid_pulse", {31'd0, rx_data_valid}, 32'd0);
        check("t1_done_pulse", {31'd0, rx_done}, 32'd0);
        tick();
        check("t1_done_ignore", {31'd0, rx_data_valid}, 32'd0);
        idle_gap();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        check("t1_rd_clear", {31'd0, rx_full}, 32'd0);

        // 8-bit LSB-first 0x12
        lsbf  = 1'b1;
        rx_en = 1'b1;
        send(32'h12, 8, 0, 8, 1'b1, 1'b0);
        check("t2_data", spi_rx_data, 32'h0000_0012);
        check("t2_done", {31'd0, rx_done}, 32'd1);
        idle_gap();
        lsbf  = 1'b0;
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;

        // 32-bit, two frames, no read -> overrun
        df           = 2'b10;
        spi_rnum_max = 13'd2;
        rx_en        = 1'b1;
        send(32'h55AA_55AA, 32, 0, 1, 1'b0, 1'b0);
        check("t3_nmax0", {31'd0, rx_num_max_en}, 32'd0);
        send(32'h55AA_55AA, 32, 1, 32, 1'b0, 1'b0);
        check("t3_data0", spi_rx_data, 32'h55AA_55AA);
        check("t3_done0", {31'd0, rx_done}, 32'd0);
        check("t3_nmax1", {31'd0, rx_num_max_en}, 32'd1);
        send(32'hAABB_CCDD, 32, 0, 32, 1'b0, 1'b0);
        check("t3_data1", spi_rx_data, 32'hAABB_CCDD);
        check("t3_ovr", {31'd0, rx_ovr}, 32'd1);
        check("t3_done1", {31'd0, rx_done}, 32'd1);
        idle_gap();
        spi_rx_rstn = 1'b0;
        #1;
        spi_rx_rstn = 1'b1;

        // same transaction, read coincides with second completion
        rx_en = 1'b1;
        send(32'h55AA_55AA, 32, 0, 32, 1'b0, 1'b0);
        send(32'hAABB_CCDD, 32, 0, 32, 1'b0, 1'b1);
        check("t4_full", {31'd0, rx_full}, 32'd1);
        check("t4_ovr", {31'd0, rx_ovr}, 32'd0);
        check("t4_data", spi_rx_data, 32'hAABB_CCDD);
        idle_gap();

        // 16-bit abort after 5 bits, then fresh 0xAABB
        df           = 2'b01;
        spi_rnum_max = 13'd1;
        rx_en        = 1'b1;
        send(32'hFFFF, 16, 0, 5, 1'b0, 1'b0);
        rx_en = 1'b0;
        tick();
        check("t5_abort_valid", {31'd0, rx_data_valid}, 32'd0);
        check("t5_abort_done", {31'd0, rx_done}, 32'd0);
        check("t5_abort_data", spi_rx_data, 32'hAABB_CCDD);
        check("t5_abort_full", {31'd0, rx_full}, 32'd1);
        rx_en = 1'b1;
        send(32'hAABB, 16, 0, 16, 1'b0, 1'b0);
        check("t5_data", spi_rx_data, 32'h0000_AABB);
        check("t5_valid", {31'd0, rx_data_valid}, 32'd1);
        check("t5_ovr", {31'd0, rx_ovr}, 32'd1);
        idle_gap();

        // df=11 behaves as 8 bits, max=0 behaves as 1
        df           = 2'b11;
        spi_rnum_max = 13'd0;
        rx_en        = 1'b1;
        send(32'hC3, 8, 0, 8, 1'b0, 1'b0);
        check("t6_data", spi_rx_data, 32'h0000_00C3);
        check("t6_done", {31'd0, rx_done}, 32'd1);
        idle_gap();
        df = 2'b00;
        spi_rnum_max = 13'd1;

`ifdef SPI_RXC_CRC_EN
        crc_en   = 1'b1;
        crc_poly = 32'h07;
        rx_en    = 1'b1;
        send(32'h01, 8, 0, 8, 1'b0, 1'b0);
        check("c1_valid", {31'd0, rx_data_valid}, 32'd1);
        check("c1_done0", {31'd0, rx_done}, 32'd0);
        check("c1_crcen", {31'd0, rx_crc_en}, 32'd1);
        check("c1_crcout", rx_crc_data_out, 32'h07);
        send(32'h07, 8, 0, 8, 1'b0, 1'b0);
        check("c1_done", {31'd0, rx_done}, 32'd1);
        check("c1_err", {31'd0, crc_err}, 32'd0);
        check("c1_valid_crc", {31'd0, rx_data_valid}, 32'd0);
        check("c1_data", spi_rx_data, 32'h01);
        check("c1_crcen_off", {31'd0, rx_crc_en}, 32'd0);
        idle_gap();
        rx_en = 1'b1;
        send(32'h01, 8, 0, 8, 1'b0, 1'b0);
        send(32'h06, 8, 0, 8, 1'b0, 1'b0);
        check("c2_err", {31'd0, crc_err}, 32'd1);
        check("c2_crcout", rx_crc_data_out, 32'h07);
        idle_gap();
        rx_en = 1'b1;
        send(32'h01, 8, 0, 8, 1'b0, 1'b0);
        send(32'h07, 8, 0, 3, 1'b0, 1'b0);
        check("c3_crcen", {31'd0, rx_crc_en}, 32'd1);
        spi_rx_rstn = 1'b0;
        #1;
        check_zero("c3_rst");
        tick();
        spi_rx_rstn = 1'b1;
        rx_en = 1'b0;
        tick();
        crc_en = 1'b0;
`else
        check("nocrc_out", rx_crc_data_out, 32'd0);
`endif

        // asynchronous reset in the middle of a data frame
        rx_en = 1'b1;
        send(32'hF0, 8, 0, 3, 1'b0, 1'b0);
        check("r_nmax", {31'd0, rx_num_max_en}, 32'd1);
        spi_rx_rstn = 1'b0;
        #1;
        check_zero("r_mid");
        rx_en = 1'b0;
        tick();
        spi_rx_rstn = 1'b1;
        tick();
        tick();
        check("r_idle_valid", {31'd0, rx_data_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
